// File: rtl/cpu_pkg.sv
// Shared types and widths for the RV32I front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int XLEN       = 32;
   localparam int OPCODE_W   = 7;
   localparam int FUN3_W     = 3;
   localparam int FUN7_W     = 7;
   localparam int INST_BYTES = 4;

   // REQ: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, inst} entries with synchronous flush and occupancy output.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full; head holds while pop is low.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          push,
   input  fetch_entry_t                  push_entry,
   input  logic                          pop,
   output fetch_entry_t                  head,
   output logic [$clog2(DEPTH+1)-1:0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t    mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;

   // Pointers and occupancy; flush empties the queue and wins over push/pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Entry storage, cleared on reset so the head reads zero out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem request, 2-entry queue to decode.
// Latency: grant in N, rvalid in N+k, inst_valid in N+k+1; one instruction per 2 cycles best case.
// Backpressure: no request while queue full; head stable while inst_ready low. Option: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [XLEN-1:0]       imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [XLEN-1:0]       imem_rdata,
   input  logic                  redirect,
   input  logic [XLEN-1:0]       redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [XLEN-1:0]       inst,
   output logic [XLEN-1:0]       inst_pc,
   output logic [OPCODE_W-1:0]   op,
   output logic [FUN3_W-1:0]     fun3,
   output logic [FUN7_W-1:0]     fun7
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic                  misalign
`endif
);

   localparam int CW = $clog2(BUF_DEPTH+1);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] target_pc;
   logic            halted;
   logic            granted;
   logic            push;
   logic            pop;
   logic [CW-1:0]   count;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target_pc = redirect_pc;
   assign halted    = misalign;

   // Sticky trap flag: any misaligned redirect stops fetching until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   misalign <= 1'b0;
      else if (redirect && redirect_pc[1:0] != 2'b00) misalign <= 1'b1;
   end
`else
   assign target_pc = redirect_pc & 32'hFFFF_FFFC;
   assign halted    = 1'b0;
`endif

   // Occupancy is sampled at request time so the response always has a free slot
   assign imem_req  = !rst && (state == S_REQ) && (count < CW'(BUF_DEPTH)) && !halted;
   assign imem_addr = fetch_pc;
   assign granted   = imem_req && imem_gnt;

   // A response arriving together with a redirect belongs to the old flow
   assign push = (state == S_WAIT) && imem_rvalid && !redirect;
   assign pop  = inst_valid && inst_ready && !redirect;

   assign push_entry = '{pc: req_pc, inst: imem_rdata};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_REQ;
      else     state <= state_nxt;
   end

   // Next state; a redirect turns any request that would be kept into one that is dropped
   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:   if (granted)     state_nxt = S_WAIT;
         S_WAIT:  if (imem_rvalid) state_nxt = S_REQ;
         S_DROP:  if (imem_rvalid) state_nxt = S_REQ;
         default:                  state_nxt = S_REQ;
      endcase
      if (redirect && state_nxt == S_WAIT) state_nxt = S_DROP;
   end

   // Fetch PC advances on grant and remembers the granted address for the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else begin
         if (redirect)     fetch_pc <= target_pc;
         else if (granted) fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
         if (granted)      req_pc   <= fetch_pc;
      end
   end

   fetch_queue #(.DEPTH(BUF_DEPTH)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (count)
   );

   assign inst_valid = (count != '0);
   assign inst       = head.inst;
   assign inst_pc    = head.pc;
   assign op         = inst[6:0];
   assign fun3       = inst[14:12];
   assign fun7       = inst[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every cycle plus directed literal checks.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [6:0]  op;
   logic [2:0]  fun3;
   logic [6:0]  fun7;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int lat     = 1;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc), .op(op), .fun3(fun3), .fun7(fun7)
`ifdef FETCH_MISALIGN_TRAP_EN
      , .misalign(misalign)
`endif
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at a negedge; advances until inst_valid or the budget runs out
   task automatic wait_valid(input int maxc, input string name);
      int n;
      n = 0;
      while (!inst_valid && n < maxc) begin
         step();
         @(negedge clk);
         n++;
      end
      chk({name, "_wait"}, 32'(inst_valid), 32'd1);
   endtask

   // Instruction memory: grants whenever imem_gnt is high, answers after lat cycles
   logic        pend = 1'b0;
   int          mcnt;
   logic [31:0] mem_addr;
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         step();
         imem_rvalid = 1'b0;
         if (pend) begin
            if (mcnt <= 1) begin
               imem_rvalid = 1'b1;
               imem_rdata  = memf(mem_addr);
               pend        = 1'b0;
            end else begin
               mcnt--;
            end
         end
         @(negedge clk);
         if (!rst && imem_req && imem_gnt) begin
            chk("single_outstanding", 32'(pend), 32'd0);
            pend     = 1'b1;
            mcnt     = lat;
            mem_addr = imem_addr;
         end
      end
   end

   // Reference model: queue of expected entries plus outstanding/stale request bookkeeping
   fetch_entry_t mq[$];
   fetch_entry_t me;
   logic        outst     = 1'b0;
   logic        stale     = 1'b0;
   logic        halted    = 1'b0;
   logic [31:0] exp_fetch = 32'h0;
   logic [31:0] mpc       = 32'h0;
   logic        mreq;
   logic        do_pop;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_req",   32'(imem_req),   32'd0);
         chk("rst_valid", 32'(inst_valid), 32'd0);
         chk("rst_inst",  inst,            32'd0);
         chk("rst_pc",    inst_pc,         32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
         chk("rst_misalign", 32'(misalign), 32'd0);
`endif
         mq.delete();
         outst     = 1'b0;
         stale     = 1'b0;
         halted    = 1'b0;
         exp_fetch = 32'h0;
      end else begin
         mreq = !outst && (mq.size() < 2) && !halted;
         chk("model_req", 32'(imem_req), 32'(mreq));
         if (mreq) chk("model_addr", imem_addr, exp_fetch);
         chk("model_valid", 32'(inst_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("model_pc",   inst_pc,     mq[0].pc);
            chk("model_inst", inst,        mq[0].inst);
            chk("model_op",   32'(op),     32'(mq[0].inst[6:0]));
            chk("model_fun3", 32'(fun3),   32'(mq[0].inst[14:12]));
            chk("model_fun7", 32'(fun7),   32'(mq[0].inst[31:25]));
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         chk("model_misalign", 32'(misalign), 32'(halted));
`endif
         do_pop = (mq.size() != 0) && inst_ready && !redirect;
         if (imem_rvalid && outst) begin
            outst = 1'b0;
            if (!stale && !redirect) begin
               me.pc   = mpc;
               me.inst = memf(mpc);
               mq.push_back(me);
            end
         end
         if (do_pop) void'(mq.pop_front());
         if (mreq && imem_gnt) begin
            outst     = 1'b1;
            stale     = 1'b0;
            mpc       = exp_fetch;
            exp_fetch = exp_fetch + 32'd4;
         end
         if (redirect) begin
            mq.delete();
            if (outst) stale = 1'b1;
            exp_fetch = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   logic found;

   initial begin
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b0;
      imem_gnt    = 1'b1;
      repeat (3) step();
      rst = 1'b0;

      // First fetches after reset; decode holds off so the queue fills
      @(negedge clk);
      chk("t1_c0_req",   32'(imem_req),   32'd1);
      chk("t1_c0_addr",  imem_addr,       32'h0);
      chk("t1_c0_valid", 32'(inst_valid), 32'd0);
      step(); @(negedge clk);
      chk("t1_c1_valid", 32'(inst_valid), 32'd0);
      step(); @(negedge clk);
      chk("t1_c2_valid", 32'(inst_valid), 32'd1);
      chk("t1_c2_pc",    inst_pc,         32'h0);
      chk("t1_c2_inst",  inst,            32'h1357_9BDF);
      chk("t1_c2_op",    32'(op),         32'h5F);
      chk("t1_c2_fun3",  32'(fun3),       32'h1);
      chk("t1_c2_fun7",  32'(fun7),       32'h9);
      repeat (9) begin step(); @(negedge clk); end
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_pc",    inst_pc,         32'h0);
      chk("hold_req",   32'(imem_req),   32'd0);

      // Drain, then redirect while the request to 0x8 is outstanding
      step(); inst_ready = 1'b1; lat = 3;
      @(negedge clk);
      chk("drain0_pc", inst_pc, 32'h0);
      step(); @(negedge clk);
      chk("drain1_pc",   inst_pc,       32'h4);
      chk("drain1_req",  32'(imem_req), 32'd1);
      chk("drain1_addr", imem_addr,     32'h8);
      step(); redirect = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      step(); redirect = 1'b0; lat = 1;
      @(negedge clk);
      chk("rd_valid", 32'(inst_valid), 32'd0);
      chk("rd_req",   32'(imem_req),   32'd0);
      wait_valid(20, "rd");
      chk("rd_pc",   inst_pc, 32'h100);
      chk("rd_inst", inst,    32'h1357_9ADF);

      // Redirect in the same cycle as a response and a pop
      step(); inst_ready = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         step(); #1;
         if (imem_rvalid && inst_valid) found = 1'b1;
      end
      chk("co_found", 32'(found), 32'd1);
      redirect = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
      @(negedge clk);
      step(); redirect = 1'b0;
      @(negedge clk);
      chk("co_valid", 32'(inst_valid), 32'd0);
      chk("co_req",   32'(imem_req),   32'd1);
      chk("co_addr",  imem_addr,       32'h200);
      wait_valid(20, "co");
      chk("co_pc", inst_pc, 32'h200);

      // Sequential fetch across the top of the address space
      step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      step(); redirect = 1'b0;
      @(negedge clk);
      wait_valid(20, "wrap0");
      chk("wrap0_pc", inst_pc, 32'hFFFF_FFF8);
      step(); @(negedge clk);
      wait_valid(20, "wrap1");
      chk("wrap1_pc", inst_pc, 32'hFFFF_FFFC);
      step(); @(negedge clk);
      wait_valid(20, "wrap2");
      chk("wrap2_pc", inst_pc, 32'h0);

      // Reset while a request is outstanding; the late response must be ignored
      step(); lat = 3;
      @(negedge clk);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         if (imem_req) found = 1'b1;
         else begin step(); @(negedge clk); end
      end
      chk("st_found", 32'(found), 32'd1);
      step(); imem_gnt = 1'b0; rst = 1'b1;
      @(negedge clk);
      step(); rst = 1'b0;
      @(negedge clk);
      chk("st_req",  32'(imem_req), 32'd1);
      chk("st_addr", imem_addr,     32'h0);
      step(); @(negedge clk);
      step(); imem_gnt = 1'b1; lat = 1;
      @(negedge clk);
      chk("st_valid", 32'(inst_valid), 32'd0);
      wait_valid(20, "st");
      chk("st_pc", inst_pc, 32'h0);

      // Misaligned redirect target
      step(); redirect = 1'b1; redirect_pc = 32'h102;
      step(); redirect = 1'b0;
      @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_flag", 32'(misalign), 32'd1);
      for (int n = 0; n < 5; n++) begin
         chk("mis_req", 32'(imem_req), 32'd0);
         step(); @(negedge clk);
      end
`else
      wait_valid(20, "mis");
      chk("mis_pc", inst_pc, 32'h100);
`endif

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the single-core RV32I CPU. Holds the program counter, issues word requests to instruction memory over a request/grant/response handshake, buffers returned instructions in a 2-entry queue, and presents them, with the `op`/`fun3`/`fun7` fields pre-split, to the decode/control stage over a valid/ready handshake. Branch and jump redirects from execute flush the queue and discard any in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `BUF_DEPTH`, 2, instruction queue entries (power of two, ≥2)

- `clk`  in  1  clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address; word-aligned
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid; in order, ≥1 cycle after grant
- `imem_rdata`  in  32  instruction word
- `redirect`  in  1  change flow (taken branch/JAL/JALR)
- `redirect_pc`  in  32  new fetch address
- `inst_valid`  out  1  queue head valid
- `inst_ready`  in  1  decode consumes head
- `inst`  out  32  head instruction
- `inst_pc`  out  32  address of head instruction
- `op`  out  7  `inst[6:0]`
- `fun3`  out  3  `inst[14:12]`
- `fun7`  out  7  `inst[31:25]`
- `misalign`  out  1  sticky misaligned-redirect flag (only with macro)

## Operation
- States: `REQ` (no request outstanding), `WAIT` (one outstanding, will be kept), `DROP` (one outstanding, will be discarded). At most one request outstanding.
- `imem_req` = state `REQ` && (occupancy + 0) < `BUF_DEPTH` && !halted; `imem_addr` = `fetch_pc`.
- `REQ`: `imem_gnt` -> `WAIT`, `fetch_pc` += 4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
- `WAIT`: `imem_rvalid` -> push `{pc, imem_rdata}`, -> `REQ`. Occupancy was checked at request time, so push never meets a full queue.
- `DROP`: `imem_rvalid` -> discard, -> `REQ`.
- Pop when `inst_valid && inst_ready`; push and pop in same cycle legal, occupancy unchanged.
- Redirect (highest priority): queue flushed, `fetch_pc` <= `redirect_pc`; if a request is outstanding or granted this cycle -> `DROP`, else `REQ`. Response arriving in the redirect cycle is discarded and its state transition still happens (`WAIT`/`DROP` -> `REQ`).
- `imem_addr` stable while `imem_req && !imem_gnt`, except on redirect (un-granted request may change address).
- Consumer may hold `inst_ready` low indefinitely; head outputs stay stable.

## Timing
- Reset values: `imem_req`=0 during reset, `fetch_pc`=`RESET_PC`, state `REQ`, queue empty, `inst_valid`=0, `inst`/`inst_pc`=0, `misalign`=0. First cycle after reset release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Grant in cycle N, `imem_rvalid` in N+k (k≥1): `inst_valid`=1 in N+k+1.
- Redirect in cycle N: `inst_valid`=0 in N+1; `imem_req` with `redirect_pc` in N+1 if state `REQ`, else after the dropped response retires.
- Throughput: one instruction per 2 cycles with 1-cycle memory (single outstanding request).
- Reset asserted mid-transfer: all state cleared immediately; a later stray `imem_rvalid` in `REQ` is ignored.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: redirect with `redirect_pc[1:0]`≠0 sets `misalign` (sticky until reset), flushes, and halts fetching (`imem_req`=0 permanently).
- Not defined: `misalign` port absent; `redirect_pc[1:0]` forced to 0, fetch continues.

## Structure
- Shared package `cpu_pkg`: `fetch_state_t` enum, `fetch_entry_t` struct `{pc, inst}`, `OPCODE_W`/`FUN3_W`/`FUN7_W` widths, `INST_BYTES`=4.
- One sub-module `fetch_queue` (parameterised FIFO of `fetch_entry_t`, flush input, occupancy output).

## Test plan
- Reset release, memory always grants, rvalid 1 cycle later -> fetches 0x0,0x4,0x8 in order; first `inst_valid` 3 cycles after release, `inst_pc`=0.
- `inst_ready` held low 10 cycles -> exactly 2 entries queued, `imem_req`=0, head stable; release -> drains in order, fetching resumes.
- Redirect to 0x100 while request to 0x8 outstanding -> response for 0x8 dropped, next `inst_pc`=0x100, no stale instruction visible.
- Redirect coincident with `imem_rvalid` and pop -> queue empty next cycle, response discarded, request to `redirect_pc` follows.
- Sequential fetch from 0xFFFF_FFF8 -> addresses 0xFFFF_FFFC then 0x0000_0000.
- With `FETCH_MISALIGN_TRAP_EN`: redirect to 0x102 -> `misalign`=1 next cycle, `imem_req` stays 0; without: next fetch address 0x100.
